// File: rtl/multiply_writeback.sv
// Sequential shift-add multiplier for the picoMIPS write-back path.
// Produces a 2*WIDTH product and writes one byte of it back to the register file.
module multiply_writeback #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     operand_a,
  input  logic [WIDTH-1:0]     operand_b,
  input  logic [ADDR_W-1:0]    dest_reg,
  input  logic                 hi_select,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic                 wb_enable,
  output logic [ADDR_W-1:0]    wb_to,
  output logic [WIDTH-1:0]     wb_data,
  output logic [1:0]           dbg_state
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // Handshake: start is accepted only on an edge where the unit is idle (busy=0);
  // starts seen while busy are dropped. done pulses for exactly one cycle together
  // with wb_enable, and the register file captures the write on the following edge.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  dest_q, dest_d;
  logic               hi_q, hi_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic [WIDTH:0]     sum;
  logic               last_iter;

  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last_iter) state_d = S_WRITE;
      S_WRITE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q == S_RUN) || (state_q == S_WRITE);
    wb_enable = (state_q == S_WRITE);
    done      = (state_q == S_WRITE);
    wb_to     = '0;
    wb_data   = '0;
    if (state_q == S_WRITE) begin
      wb_to   = dest_q;
      wb_data = hi_q ? product_q[2*WIDTH-1:WIDTH] : product_q[WIDTH-1:0];
    end
  end

  assign product   = product_q;
  assign dbg_state = state_q;

  // One iteration: conditional add into the upper half, then shift {carry, acc, mplier} right.
  always_comb begin
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    dest_d    = dest_q;
    hi_d      = hi_q;
    product_d = product_q;
    sum       = {1'b0, acc_q} + (mplier_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mcand_d  = operand_a;
          mplier_d = operand_b;
          dest_d   = dest_reg;
          hi_d     = hi_select;
          acc_d    = '0;
          cnt_d    = '0;
        end
      end
      S_RUN: begin
        acc_d    = sum[WIDTH:1];
        mplier_d = {sum[0], mplier_q[WIDTH-1:1]};
        cnt_d    = cnt_q + CNT_W'(1);
        if (last_iter) begin
          product_d = {sum[WIDTH:1], sum[0], mplier_q[WIDTH-1:1]};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_q   <= '0;
      acc_q     <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      dest_q    <= '0;
      hi_q      <= 1'b0;
      product_q <= '0;
    end else begin
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
      dest_q    <= dest_d;
      hi_q      <= hi_d;
      product_q <= product_d;
    end
  end

endmodule

// File: tb/tb_multiply_writeback.sv
// Directed bench for multiply_writeback: timeline model of the multiply/write-back
// transaction, per-cycle output comparison, write scoreboard and a small register file.
module tb_multiply_writeback;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset, start, hi_select;
  logic [W-1:0] operand_a, operand_b;
  logic [2:0]   dest_reg;
  logic         busy, done, wb_enable;
  logic [15:0]  product;
  logic [2:0]   wb_to;
  logic [W-1:0] wb_data;
  logic [1:0]   dbg_state;

  int checks = 0;
  int errors = 0;

  multiply_writeback #(.WIDTH(W), .ADDR_W(3)) dut (
    .clk(clk), .reset(reset), .start(start),
    .operand_a(operand_a), .operand_b(operand_b),
    .dest_reg(dest_reg), .hi_select(hi_select),
    .busy(busy), .done(done), .product(product),
    .wb_enable(wb_enable), .wb_to(wb_to), .wb_data(wb_data),
    .dbg_state(dbg_state)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // Register file written by the DUT
  logic         tb_rf_clear;
  logic [W-1:0] rf [8];
  always @(posedge clk) begin
    if (tb_rf_clear) begin
      for (int i = 0; i < 8; i++) rf[i] <= '0;
    end else if (wb_enable === 1'b1) begin
      rf[wb_to] <= wb_data;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: an accepted start produces a*b, a write 9 edges later, and
  // the unit is free again 10 edges after acceptance.
  int           cyc = 0;
  bit           m_active = 0;
  int           m_age = 0;
  logic [W-1:0] m_a, m_b;
  logic [2:0]   m_dest;
  logic         m_hi;
  logic [15:0]  m_prod = '0;
  logic [W-1:0] exp_rf [8];
  logic [10:0]  exp_q [$];
  int           acc_edges_q [$];
  int           wr_edges_q [$];
  int           n_writes = 0;
  wire  [W-1:0] m_wbyte = m_hi ? m_prod[15:8] : m_prod[7:0];

  always @(posedge clk) begin
    logic [15:0] p;
    cyc++;
    if (wb_enable === 1'b1) begin
      n_writes++;
      wr_edges_q.push_back(cyc);
    end
    if (tb_rf_clear) begin
      for (int i = 0; i < 8; i++) exp_rf[i] = '0;
    end else if (m_active && m_age == 8) begin
      exp_rf[m_dest] = m_wbyte;
    end
    if (reset) begin
      m_active = 0;
      m_age    = 0;
      m_prod   = '0;
      exp_q.delete();
    end else if (m_active) begin
      m_age++;
      if (m_age == 8) m_prod = 16'(m_a) * 16'(m_b);
      if (m_age == 9) m_active = 0;
    end else if (start) begin
      m_active = 1;
      m_age    = 0;
      m_a      = operand_a;
      m_b      = operand_b;
      m_dest   = dest_reg;
      m_hi     = hi_select;
      p        = 16'(operand_a) * 16'(operand_b);
      acc_edges_q.push_back(cyc);
      exp_q.push_back({dest_reg, hi_select ? p[15:8] : p[7:0]});
    end
  end

  // Compare process on the falling edge
  bit chk_en = 0;
  always @(negedge clk) begin
    logic        exp_wr;
    logic [10:0] item;
    if (chk_en) begin
      exp_wr = m_active && (m_age == 8);
      check("busy", busy, m_active);
      check("done", done, exp_wr);
      check("wb_enable", wb_enable, exp_wr);
      check("wb_to", wb_to, exp_wr ? m_dest : 3'd0);
      check("wb_data", wb_data, exp_wr ? m_wbyte : 8'd0);
      check("product", product, m_prod);
      if (wb_enable === 1'b1) begin
        check("sb_write_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          item = exp_q.pop_front();
          check("sb_write", {wb_to, wb_data}, item);
        end
      end
    end
  end

  // Driver tasks
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2:0] d, input logic h);
    operand_a = a;
    operand_b = b;
    dest_reg  = d;
    hi_select = h;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    operand_a = W'($urandom_range(0, 255));
    operand_b = W'($urandom_range(0, 255));
    dest_reg  = 3'($urandom_range(0, 7));
    hi_select = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy !== 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({name, "_idle_timeout"}, n < 40, 1);
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   d;
    logic         h;
    logic [15:0]  p;
    logic [W-1:0] byte_exp;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int e0, w0, a0, wr0;
    vecs[0] = '{8'h01, 8'hFF, 3'd1, 1'b0, 16'h00FF, 8'hFF};
    vecs[1] = '{8'h80, 8'h02, 3'd6, 1'b1, 16'h0100, 8'h01};
    vecs[2] = '{8'hAB, 8'hCD, 3'd0, 1'b1, 16'h88EF, 8'h88};
    vecs[3] = '{8'hFF, 8'h01, 3'd7, 1'b1, 16'h00FF, 8'h00};

    reset = 1'b1; start = 1'b0; hi_select = 1'b0;
    operand_a = '0; operand_b = '0; dest_reg = '0;
    tb_rf_clear = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    tb_rf_clear = 1'b0;
    chk_en = 1;
    check("reset_busy", busy, 0);
    check("reset_product", product, 16'h0000);
    check("reset_wb_enable", wb_enable, 0);

    // Low-byte write-back
    start_op(8'h0F, 8'h0D, 3'd3, 1'b0);
    e0 = acc_edges_q[$];
    wait_idle("t1");
    check("t1_product", product, 16'h00C3);
    check("t1_latency", wr_edges_q[$] - e0, 9);
    check("t1_rf3", rf[3], 8'hC3);

    // High byte, then low byte of the same product
    start_op(8'hFF, 8'hFF, 3'd5, 1'b1);
    wait_idle("t2a");
    check("t2a_product", product, 16'hFE01);
    check("t2a_rf5", rf[5], 8'hFE);
    start_op(8'hFF, 8'hFF, 3'd5, 1'b0);
    wait_idle("t2b");
    check("t2b_rf5", rf[5], 8'h01);

    // Start while busy is dropped
    w0 = n_writes;
    a0 = acc_edges_q.size();
    start_op(8'h02, 8'h03, 3'd2, 1'b0);
    repeat (3) @(negedge clk);
    operand_a = 8'h10; operand_b = 8'h10; dest_reg = 3'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle("t3");
    repeat (2) @(negedge clk);
    check("t3_writes", n_writes - w0, 1);
    check("t3_accepts", acc_edges_q.size() - a0, 1);
    check("t3_product", product, 16'h0006);
    check("t3_rf2", rf[2], 8'h06);

    // Reset mid-operation
    start_op(8'hA5, 8'h3C, 3'd4, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t4_busy", busy, 0);
    check("t4_product", product, 16'h0000);
    w0 = n_writes;
    repeat (12) @(negedge clk);
    check("t4_no_write", n_writes - w0, 0);
    check("t4_rf4", rf[4], 8'h00);
    check("t4_rf3", rf[3], 8'hC3);

    // Directed vectors, including destination register 0
    for (int i = 0; i < 4; i++) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].h);
      wait_idle("vec");
      check("vec_product", product, vecs[i].p);
      check("vec_rf", rf[vecs[i].d], vecs[i].byte_exp);
    end

    // Zero operand with start held high: accepts at E0 and E10, writes at E9 and E19
    a0  = acc_edges_q.size();
    wr0 = wr_edges_q.size();
    operand_a = 8'h00; operand_b = 8'h7F; dest_reg = 3'd1; hi_select = 1'b0;
    start = 1'b1;
    repeat (11) @(negedge clk);
    start = 1'b0;
    wait_idle("t5");
    repeat (2) @(negedge clk);
    check("t5_accepts", acc_edges_q.size() - a0, 2);
    check("t5_writes", wr_edges_q.size() - wr0, 2);
    e0 = acc_edges_q[a0];
    check("t5_second_accept", acc_edges_q[a0 + 1] - e0, 10);
    check("t5_first_write", wr_edges_q[wr0] - e0, 9);
    check("t5_second_write", wr_edges_q[wr0 + 1] - e0, 19);
    check("t5_rf1", rf[1], 8'h00);

    // Reset wins over start on the same edge
    a0 = acc_edges_q.size();
    reset = 1'b1; start = 1'b1; operand_a = 8'h11; operand_b = 8'h22;
    @(negedge clk);
    check("t6_busy_in_reset", busy, 0);
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    check("t6_busy_after", busy, 0);
    check("t6_accepts", acc_edges_q.size() - a0, 0);

    repeat (2) @(negedge clk);
    for (int i = 0; i < 8; i++) check("final_rf", rf[i], exp_rf[i]);
    check("final_sb_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
